i2c_cpu_cpu_debug_ocimem_arbiter: RTL and testbench

I2C_CPU_CPU_DEBUG_OCIMEM_ARBITER -- requirements
Module: i2c_cpu_cpu_debug_ocimem_arbiter

---
 rtl/i2c_cpu_cpu_debug_ocimem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_cpu_cpu_debug_ocimem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cpu_cpu_debug_ocimem_arbiter.sv
// Purpose : shares one single-port 256x32 OCI debug RAM between JTAG monitor commands and an Avalon slave port.
// Latency : a granted request reaches the RAM one cycle after it is presented; reads take one more cycle (1-cycle RAM latency).
// Backpressure: Avalon stalls via avs_waitrequest; JTAG has one pending slot, and pulses arriving while busy are dropped and flagged.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   jdo, take_*_ocimem_*       JTAG data word and 1-cycle command pulses
//   avs_*                      Avalon debug_mem slave (address, strobes, data, byteenable, readdata, waitrequest)
//   ram_*                      shared OCI RAM port (address, write enable, write data, byteenable, read data)
//   MonDReg                    JTAG monitor data register (last JTAG read result)
//   jtag_busy, jtag_overrun    JTAG command in flight / sticky dropped-command flag

module i2c_cpu_cpu_debug_ocimem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic [7:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [7:0]  ram_addr,
    output logic        ram_wr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_byteenable,
    input  logic [31:0] ram_rdata,
    output logic [31:0] MonDReg,
    output logic        jtag_busy,
    output logic        jtag_overrun
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        J_RD     = 3'd1,
        J_RD_CAP = 3'd2,
        J_WR     = 3'd3,
        A_RD     = 3'd4,
        A_RD_CAP = 3'd5,
        A_WR     = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  mon_areg;
    logic [31:0] rdata_q;
    logic        pend;
    logic        cmd_wr;
    logic [31:0] cmd_wdata;
    logic        last_grant;   // 1 = Avalon won the last contended grant

    logic        j_active;
    logic        any_pulse;
    logic        accept;
    logic        new_access;
    logic        j_req;
    logic        a_req;
    logic        j_is_wr;
    logic        grant_j;
    logic        grant_a;

    // jdo bits outside the command fields carry nothing for this block.
    logic        unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign j_active  = (state == J_RD) || (state == J_RD_CAP) || (state == J_WR);
    assign jtag_busy = pend || j_active;
    assign any_pulse = take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b;
    assign accept    = any_pulse && !jtag_busy;

    // A freshly accepted command competes in the same IDLE cycle as the
    // pending register, so a lone JTAG pulse is serviced the next cycle.
    assign new_access = accept && (take_action_ocimem_b || take_no_action_ocimem_a ||
                                   (take_action_ocimem_a && jdo[35]));
    assign j_req   = pend || new_access;
    assign a_req   = avs_read || avs_write;
    assign j_is_wr = pend ? cmd_wr : take_action_ocimem_b;

    // Next-state and grant decision.
    always_comb begin
        state_nxt = state;
        grant_j   = 1'b0;
        grant_a   = 1'b0;
        case (state)
            IDLE: begin
                if (j_req && a_req) begin
                    grant_j = last_grant;
                    grant_a = !last_grant;
                end else begin
                    grant_j = j_req;
                    grant_a = a_req;
                end
                if (grant_j) begin
                    state_nxt = j_is_wr ? J_WR : J_RD;
                end else if (grant_a) begin
                    // read+write together is handled as a write
                    state_nxt = avs_write ? A_WR : A_RD;
                end
            end
            J_RD:     state_nxt = J_RD_CAP;
            A_RD:     state_nxt = A_RD_CAP;
            J_RD_CAP: state_nxt = IDLE;
            J_WR:     state_nxt = IDLE;
            A_RD_CAP: state_nxt = IDLE;
            A_WR:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // RAM drive. Gated by reset so an access interrupted by reset never
    // writes in the reset cycle.
    always_comb begin
        ram_addr       = 8'h00;
        ram_wr         = 1'b0;
        ram_wdata      = 32'h0;
        ram_byteenable = 4'h0;
        if (!reset) begin
            case (state)
                J_RD: begin
                    ram_addr = mon_areg;
                end
                J_WR: begin
                    ram_addr       = mon_areg;
                    ram_wr         = 1'b1;
                    ram_wdata      = cmd_wdata;
                    ram_byteenable = 4'hF;
                end
                A_RD: begin
                    ram_addr       = avs_address;
                    ram_byteenable = avs_byteenable;
                end
                A_WR: begin
                    ram_addr       = avs_address;
                    ram_wr         = 1'b1;
                    ram_wdata      = avs_writedata;
                    ram_byteenable = avs_byteenable;
                end
                default: ;
            endcase
        end
    end

    assign avs_waitrequest = a_req && !((state == A_RD_CAP) || (state == A_WR));

    // The capture cycle is also the cycle waitrequest drops, so the RAM
    // data is forwarded directly then and held from the register afterwards.
    assign avs_readdata = (state == A_RD_CAP) ? ram_rdata : rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mon_areg     <= 8'h00;
            MonDReg      <= 32'h0;
            rdata_q      <= 32'h0;
            pend         <= 1'b0;
            cmd_wr       <= 1'b0;
            cmd_wdata    <= 32'h0;
            last_grant   <= 1'b1;
            jtag_overrun <= 1'b0;
        end else begin
            state <= state_nxt;

            // Accepted command: b beats a beats no_action_a.
            if (accept) begin
                if (take_action_ocimem_b) begin
                    cmd_wr    <= 1'b1;
                    cmd_wdata <= jdo[34:3];
                end else if (take_action_ocimem_a) begin
                    cmd_wr   <= 1'b0;
                    mon_areg <= jdo[33:26];
                end else begin
                    cmd_wr <= 1'b0;
                end
            end

            if (grant_j) begin
                pend <= 1'b0;
            end else if (new_access) begin
                pend <= 1'b1;
            end

            if (any_pulse && jtag_busy) begin
                jtag_overrun <= 1'b1;
            end

            // Only contended grants flip the fairness bit.
            if (grant_j && a_req) begin
                last_grant <= 1'b0;
            end else if (grant_a && j_req) begin
                last_grant <= 1'b1;
            end

            if (state == J_RD_CAP) begin
                MonDReg  <= ram_rdata;
                mon_areg <= mon_areg + 8'd1;
            end
            if (state == J_WR) begin
                mon_areg <= mon_areg + 8'd1;
            end
            if (state == A_RD_CAP) begin
                rdata_q <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_i2c_cpu_cpu_debug_ocimem_arbiter.sv
// Purpose : self-checking bench for the OCI debug RAM arbiter with a behavioural 256x32 RAM.
// Latency : expected RAM writes, JTAG read data and Avalon read data are queued at stimulus time and checked on completion.
// Backpressure: Avalon transactions hold strobes until waitrequest drops; every wait is cycle-bounded.

module tb_i2c_cpu_cpu_debug_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        jtag_overrun;

    always #5 clk = ~clk;

    i2c_cpu_cpu_debug_ocimem_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wr                  (ram_wr),
        .ram_wdata               (ram_wdata),
        .ram_byteenable          (ram_byteenable),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    // Behavioural RAM: synchronous read, byte-enabled write, plus a backdoor for preloads.
    logic [31:0] mem [256];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [31:0] bd_dat;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_dat;
        end else if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_byteenable[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        ram_rdata <= mem[ram_addr];
    end

    int          n_chk;
    int          n_fail;
    logic [43:0] wr_q [$];   // {byteenable, addr, data}
    logic [32:0] j_q  [$];   // {is_read, expected MonDReg}
    logic [31:0] avs_q[$];
    logic        busy_prev;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_a(input logic rd, input logic [7:0] a);
        logic [37:0] r;
        r        = 38'h0;
        r[35]    = rd;
        r[33:26] = a;
        return r;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] r;
        r       = 38'h0;
        r[34:3] = d;
        return r;
    endfunction

    // mask = {b, no_action_a, a}; pulses are held for exactly one cycle.
    task automatic pulse(input logic [2:0] mask, input logic [37:0] d);
        jdo                     = d;
        take_action_ocimem_a    = mask[0];
        take_no_action_ocimem_a = mask[1];
        take_action_ocimem_b    = mask[2];
        tick();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic backdoor(input logic [7:0] a, input logic [31:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_dat  = d;
        tick();
        bd_we   = 1'b0;
    endtask

    task automatic jtag_wait;
        int n;
        n = 0;
        while (jtag_busy && n < 50) begin
            tick();
            n++;
        end
        chk("jtag_idle", {63'h0, jtag_busy}, 64'h0);
    endtask

    // Avalon master: holds strobes until waitrequest is low, counts stalled cycles.
    task automatic avs(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int exp_waits, input string tag);
        int          waits;
        logic [31:0] e;
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_read       = rd;
        avs_write      = wr;
        waits          = 0;
        @(negedge clk);
        while (avs_waitrequest && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        chk({tag, "_waits"}, 64'(waits), 64'(exp_waits));
        if (!wr) begin
            e = (avs_q.size() != 0) ? avs_q.pop_front() : 32'hx;
            chk({tag, "_rdata"}, {32'h0, avs_readdata}, {32'h0, e});
        end
        @(posedge clk);
        #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        wr_q.delete();
        j_q.delete();
        avs_q.delete();
        reset = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        busy_prev = 1'b0;
        reset = 1'b1;
        jdo = 38'h0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs_address = 8'h0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = 32'h0;
        avs_byteenable = 4'h0;
        bd_we = 1'b0;
        bd_addr = 8'h0;
        bd_dat = 32'h0;

        // Completion monitor: RAM writes and JTAG command completions.
        fork
            forever begin
                logic [43:0] ew;
                logic [32:0] ej;
                @(negedge clk);
                if (reset) begin
                    busy_prev = 1'b0;
                end else begin
                    if (ram_wr) begin
                        ew = (wr_q.size() != 0) ? wr_q.pop_front() : 44'hx;
                        chk("ram_write", {20'h0, ram_byteenable, ram_addr, ram_wdata}, {20'h0, ew});
                    end
                    if (busy_prev && !jtag_busy) begin
                        ej = (j_q.size() != 0) ? j_q.pop_front() : 33'hx;
                        if (ej[32] === 1'b1) chk("jtag_mondreg", {32'h0, MonDReg}, {32'h0, ej[31:0]});
                    end
                    busy_prev = jtag_busy;
                end
            end
        join_none

        // Reset state, observed while reset is still asserted.
        tick();
        @(negedge clk);
        chk("rst_mondreg", {32'h0, MonDReg}, 64'h0);
        chk("rst_rdata", {32'h0, avs_readdata}, 64'h0);
        chk("rst_ram_wr", {63'h0, ram_wr}, 64'h0);
        chk("rst_ram_addr", {56'h0, ram_addr}, 64'h0);
        chk("rst_busy", {63'h0, jtag_busy}, 64'h0);
        chk("rst_overrun", {63'h0, jtag_overrun}, 64'h0);
        @(posedge clk);
        #1;
        do_reset();

        backdoor(8'h11, 32'hA5A5_0011);
        backdoor(8'h20, 32'h1234_5678);
        backdoor(8'h30, 32'h3030_3030);
        backdoor(8'h31, 32'h3131_3131);

        // JTAG write then read back, then read at the incremented address.
        pulse(3'b001, mk_a(1'b0, 8'h10));
        chk("addr_only_busy", {63'h0, jtag_busy}, 64'h0);
        wr_q.push_back({4'hF, 8'h10, 32'hDEAD_BEEF});
        j_q.push_back({1'b0, 32'h0});
        pulse(3'b100, mk_b(32'hDEAD_BEEF));
        jtag_wait();
        chk("mem_10", {32'h0, mem[8'h10]}, 64'hDEAD_BEEF);
        j_q.push_back({1'b1, 32'hDEAD_BEEF});
        pulse(3'b001, mk_a(1'b1, 8'h10));
        jtag_wait();
        j_q.push_back({1'b1, 32'hA5A5_0011});
        pulse(3'b010, 38'h0);
        jtag_wait();

        // Address wrap 0xFF -> 0x00.
        pulse(3'b001, mk_a(1'b0, 8'hFF));
        wr_q.push_back({4'hF, 8'hFF, 32'hCAFE_F00D});
        j_q.push_back({1'b0, 32'h0});
        pulse(3'b100, mk_b(32'hCAFE_F00D));
        jtag_wait();
        wr_q.push_back({4'hF, 8'h00, 32'h0BAD_C0DE});
        j_q.push_back({1'b0, 32'h0});
        pulse(3'b100, mk_b(32'h0BAD_C0DE));
        jtag_wait();

        // Simultaneous pulses: b over a (address 0x01), then a over no_action.
        wr_q.push_back({4'hF, 8'h01, 32'h1357_2468});
        j_q.push_back({1'b0, 32'h0});
        pulse(3'b101, mk_b(32'h1357_2468));
        jtag_wait();
        j_q.push_back({1'b1, 32'h3131_3131});
        pulse(3'b011, mk_a(1'b1, 8'h31));
        jtag_wait();

        // Avalon read, byte-enabled write, read-back, read+write as write.
        avs_q.push_back(32'h1234_5678);
        avs(1'b1, 1'b0, 8'h20, 32'h0, 4'hF, 2, "avs_rd20");
        @(negedge clk);
        chk("avs_rdata_hold", {32'h0, avs_readdata}, 64'h1234_5678);
        @(posedge clk);
        #1;
        wr_q.push_back({4'h5, 8'h20, 32'hAABB_CCDD});
        avs(1'b0, 1'b1, 8'h20, 32'hAABB_CCDD, 4'h5, 1, "avs_wr20");
        avs_q.push_back(32'h12BB_56DD);
        avs(1'b1, 1'b0, 8'h20, 32'h0, 4'hF, 2, "avs_rd20b");
        wr_q.push_back({4'hF, 8'h21, 32'h2121_2121});
        avs(1'b1, 1'b1, 8'h21, 32'h2121_2121, 4'hF, 1, "avs_rw21");

        // JTAG write arriving mid Avalon read queues behind it (MonAReg = 0x32).
        avs_q.push_back(32'h12BB_56DD);
        wr_q.push_back({4'hF, 8'h32, 32'h7777_8888});
        j_q.push_back({1'b0, 32'h0});
        fork
            avs(1'b1, 1'b0, 8'h20, 32'h0, 4'hF, 2, "avs_rd_jq");
            begin
                tick();
                pulse(3'b100, mk_b(32'h7777_8888));
            end
        join
        jtag_wait();

        // Contention after reset: JTAG first, then Avalon first on the repeat.
        do_reset();
        j_q.push_back({1'b1, 32'h3030_3030});
        wr_q.push_back({4'hF, 8'h40, 32'h4040_4040});
        fork
            pulse(3'b001, mk_a(1'b1, 8'h30));
            avs(1'b0, 1'b1, 8'h40, 32'h4040_4040, 4'hF, 4, "tie1_avs");
        join
        jtag_wait();
        j_q.push_back({1'b1, 32'h3131_3131});
        wr_q.push_back({4'hF, 8'h41, 32'h4141_4141});
        fork
            pulse(3'b010, 38'h0);
            avs(1'b0, 1'b1, 8'h41, 32'h4141_4141, 4'hF, 1, "tie2_avs");
        join
        chk("tie2_jtag_queued", {63'h0, jtag_busy}, 64'h1);
        jtag_wait();

        // Overrun: second no_action pulse while the first is in flight (MonAReg = 0x32).
        j_q.push_back({1'b1, 32'h7777_8888});
        pulse(3'b010, 38'h0);
        pulse(3'b010, 38'h0);
        chk("ovr_set", {63'h0, jtag_overrun}, 64'h1);
        jtag_wait();
        wr_q.push_back({4'hF, 8'h33, 32'h3333_3333});
        j_q.push_back({1'b0, 32'h0});
        pulse(3'b100, mk_b(32'h3333_3333));
        jtag_wait();
        chk("ovr_sticky", {63'h0, jtag_overrun}, 64'h1);

        // Reset during J_WR at 0x34 aborts the write.
        backdoor(8'h34, 32'h3434_3434);
        pulse(3'b100, mk_b(32'h9999_9999));
        reset = 1'b1;
        @(negedge clk);
        chk("rstwr_ram_wr", {63'h0, ram_wr}, 64'h0);
        chk("rstwr_ram_addr", {56'h0, ram_addr}, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_q.delete();
        j_q.delete();
        tick();
        chk("rstwr_mem34", {32'h0, mem[8'h34]}, 64'h3434_3434);
        chk("rstwr_mondreg", {32'h0, MonDReg}, 64'h0);
        chk("rstwr_busy", {63'h0, jtag_busy}, 64'h0);
        chk("rstwr_overrun", {63'h0, jtag_overrun}, 64'h0);

        tick();
        chk("wr_q_drained", 64'(wr_q.size()), 64'h0);
        chk("j_q_drained", 64'(j_q.size()), 64'h0);
        chk("avs_q_drained", 64'(avs_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
